// File: rtl/switch_scan_debouncer.sv
// Multi-switch debouncer: one shared prescaler tick starts a round-robin scan that
// visits one switch per clk, updating its stability counter and debounced level.
module switch_scan_debouncer #(
    parameter int N_SW       = 4,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw,
    output logic [N_SW-1:0] db_level,
    output logic [N_SW-1:0] db_rise,
    output logic [N_SW-1:0] db_fall,
    output logic            sample_tick
);

    localparam int IDX_W = (N_SW > 1) ? $clog2(N_SW) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT);
    localparam int DIV_W = $clog2(TICK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CNT - 1);

    // A scan must finish before the next tick can arrive.
    if (TICK_DIV < 2 * N_SW) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 2*N_SW");
    end
    if (N_SW < 1 || N_SW > 16) begin : g_bad_n_sw
        $error("N_SW must be in 1..16");
    end
    if (STABLE_CNT < 2 || STABLE_CNT > 255) begin : g_bad_stable_cnt
        $error("STABLE_CNT must be in 2..255");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    logic [N_SW-1:0]            sync1_r;
    logic [N_SW-1:0]            sw_s;
    logic [DIV_W-1:0]           presc_r;
    logic                       sample_tick_r;
    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [IDX_W-1:0]           idx_r;
    logic [IDX_W-1:0]           idx_nxt_s;
    logic                       scan_en_s;
    logic [N_SW-1:0][CNT_W-1:0] cnt_r;
    logic [N_SW-1:0]            db_level_r;
    logic [N_SW-1:0]            db_rise_r;
    logic [N_SW-1:0]            db_fall_r;
    logic                       cur_sw_s;
    logic                       cur_lvl_s;
    logic [CNT_W-1:0]           cur_cnt_s;
    logic [CNT_W-1:0]           cnt_nxt_s;
    logic                       flip_s;

    // Two-flop synchronizer for the raw switch levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= '0;
            sw_s    <= '0;
        end else begin
            sync1_r <= sw;
            sw_s    <= sync1_r;
        end
    end

    // Prescaler; the tick is registered so it lands one cycle after the wrap count.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r       <= '0;
            sample_tick_r <= 1'b0;
        end else begin
            sample_tick_r <= (presc_r == DIV_LAST);
            presc_r       <= (presc_r == DIV_LAST) ? '0 : presc_r + DIV_W'(1);
        end
    end

    // FSM state and scan index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // FSM next-state: a tick starts a scan that walks idx 0..N_SW-1.
    always_comb begin
        state_nxt_s = IDLE;
        idx_nxt_s   = '0;
        case (state_r)
            IDLE: begin
                if (sample_tick_r) begin
                    state_nxt_s = SCAN;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = '0;
                end
            end
            SCAN: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = SCAN;
                    idx_nxt_s   = idx_r + IDX_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        scan_en_s = 1'b0;
        case (state_r)
            IDLE:    scan_en_s = 1'b0;
            SCAN:    scan_en_s = 1'b1;
            default: scan_en_s = 1'b0;
        endcase
    end

    // Stability decision for the switch in the current slot.
    always_comb begin
        cur_sw_s  = sw_s[idx_r];
        cur_lvl_s = db_level_r[idx_r];
        cur_cnt_s = cnt_r[idx_r];
        flip_s    = 1'b0;
        cnt_nxt_s = '0;
        if (cur_sw_s == cur_lvl_s) begin
            flip_s    = 1'b0;
            cnt_nxt_s = '0;
        end else if (cur_cnt_s == CNT_MAX) begin
            flip_s    = 1'b1;
            cnt_nxt_s = '0;
        end else begin
            flip_s    = 1'b0;
            cnt_nxt_s = cur_cnt_s + CNT_W'(1);
        end
    end

    // Per-switch counters, debounced levels and the single-cycle edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            db_level_r <= '0;
            db_rise_r  <= '0;
            db_fall_r  <= '0;
        end else begin
            db_rise_r <= '0;
            db_fall_r <= '0;
            if (scan_en_s) begin
                cnt_r[idx_r] <= cnt_nxt_s;
                if (flip_s) begin
                    db_level_r[idx_r] <= ~cur_lvl_s;
                    db_rise_r[idx_r]  <= ~cur_lvl_s;
                    db_fall_r[idx_r]  <= cur_lvl_s;
                end
            end
        end
    end

    assign db_level    = db_level_r;
    assign db_rise     = db_rise_r;
    assign db_fall     = db_fall_r;
    assign sample_tick = sample_tick_r;

endmodule

// File: tb/tb_switch_scan_debouncer.sv
// Directed bench for switch_scan_debouncer: expected pulses are queued as stimulus
// is applied and matched against every pulse the DUT emits.
module tb_switch_scan_debouncer;

    localparam int NSW = 4;
    localparam int TD  = 10;
    localparam int SC  = 3;

    logic           clk;
    logic           rst;
    logic [NSW-1:0] sw;
    logic [NSW-1:0] db_level;
    logic [NSW-1:0] db_rise;
    logic [NSW-1:0] db_fall;
    logic           sample_tick;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int             at_cyc;
        logic [NSW-1:0] rise;
        logic [NSW-1:0] fall;
        logic [NSW-1:0] level;
    } ev_t;

    ev_t            exp_q[$];
    logic [NSW-1:0] exp_lvl;

    switch_scan_debouncer #(
        .N_SW      (NSW),
        .TICK_DIV  (TD),
        .STABLE_CNT(SC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .db_level   (db_level),
        .db_rise    (db_rise),
        .db_fall    (db_fall),
        .sample_tick(sample_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset edge; ticks are visible when cyc is a nonzero multiple of TD.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // A change driven at the negedge where cyc==c is first sampled by the scan whose slot i
    // ends at edge TD*m+2+i with c <= TD*m+i-1; the pulse follows SC scans later.
    function automatic int exp_edge(input int c, input int i);
        int m;
        m = 1;
        while (TD * m + i < c + 1) m++;
        return TD * (m + SC - 1) + 2 + i;
    endfunction

    task automatic push_ev(input int at, input int i, input bit is_rise);
        ev_t e;
        exp_lvl[i] = is_rise;
        e.at_cyc = at;
        e.rise   = is_rise ? (4'b0001 << i) : 4'b0000;
        e.fall   = is_rise ? 4'b0000 : (4'b0001 << i);
        e.level  = exp_lvl;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (cyc == n) return;
        end
        n_vec++;
        n_err++;
        $error("FAIL wait_cyc observed=timeout expected=cyc %0d", n);
    endtask

    // Monitor: tick cadence every cycle, and every pulse popped against the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            n_vec++;
            assert (sample_tick === ((cyc != 0) && (cyc % TD == 0))) else begin
                n_err++;
                $error("FAIL tick cyc=%0d observed=%b expected=%b", cyc, sample_tick,
                       ((cyc != 0) && (cyc % TD == 0)));
            end
            if ((db_rise | db_fall) !== 4'b0000) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $error("FAIL unexpected_pulse cyc=%0d observed rise=%b fall=%b expected none",
                           cyc, db_rise, db_fall);
                end else begin
                    e = exp_q.pop_front();
                    assert (cyc == e.at_cyc && db_rise === e.rise && db_fall === e.fall
                            && db_level === e.level) else begin
                        n_err++;
                        $error("FAIL pulse observed cyc=%0d rise=%b fall=%b lvl=%b expected cyc=%0d rise=%b fall=%b lvl=%b",
                               cyc, db_rise, db_fall, db_level, e.at_cyc, e.rise, e.fall, e.level);
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        sw      = 4'hF;
        exp_lvl = 4'b0000;

        // Reset held for 3 clk with all switches high.
        @(posedge clk);
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_outs", {db_level, db_rise, db_fall, sample_tick}, 32'd0);
        end
        rst = 1'b0;
        sw  = 4'b0100;
        push_ev(exp_edge(0, 2), 2, 1'b1);
        wait_cyc(1);
        chk("first_edge_outs", {db_level, db_rise, db_fall, sample_tick}, 32'd0);
        wait_cyc(9);
        chk("tick_before", sample_tick, 32'd0);
        wait_cyc(10);
        chk("first_tick", sample_tick, 32'd1);

        // Clean press then release on switch 2.
        wait_cyc(35);
        chk("press_level", db_level, 32'h4);
        wait_cyc(40);
        sw = 4'b0000;
        push_ev(exp_edge(40, 2), 2, 1'b0);
        wait_cyc(65);
        chk("release_level", db_level, 32'h0);

        // Bounce on switch 0 every 7 clk, settling high.
        for (int k = 0; k < 9; k++) begin
            wait_cyc(70 + 7 * k);
            sw[0] = (k % 2 == 0);
        end
        push_ev(exp_edge(126, 0), 0, 1'b1);
        wait_cyc(153);
        chk("bounce_level", db_level, 32'h1);

        // Back to zero, then all four switches pressed together.
        wait_cyc(160);
        sw = 4'b0000;
        push_ev(exp_edge(160, 0), 0, 1'b0);
        wait_cyc(205);
        sw = 4'hF;
        for (int i = 0; i < NSW; i++) push_ev(exp_edge(205, i), i, 1'b1);
        wait_cyc(236);
        chk("all_level", db_level, 32'hF);

        // Release all, then a two-tick glitch on switch 3.
        wait_cyc(245);
        sw = 4'b0000;
        for (int i = 0; i < NSW; i++) push_ev(exp_edge(245, i), i, 1'b0);
        wait_cyc(285);
        sw = 4'b1000;
        wait_cyc(305);
        sw = 4'b0000;
        wait_cyc(320);
        chk("glitch_level", db_level, 32'h0);

        // Clean press on switch 3 needs a full requalification.
        wait_cyc(325);
        sw = 4'b1000;
        push_ev(exp_edge(325, 3), 3, 1'b1);
        wait_cyc(356);
        chk("requal_level", db_level, 32'h8);

        // Reset during slot 1 of the scan that would raise switch 1.
        wait_cyc(365);
        sw = 4'b1010;
        wait_cyc(392);
        chk("pre_rst_level", db_level, 32'h8);
        rst = 1'b1;
        @(negedge clk);
        chk("midscan_rst_outs", {db_level, db_rise, db_fall, sample_tick}, 32'd0);
        chk("q_empty_at_rst", exp_q.size(), 32'd0);
        rst     = 1'b0;
        exp_lvl = 4'b0000;
        push_ev(exp_edge(0, 1), 1, 1'b1);
        push_ev(exp_edge(0, 3), 3, 1'b1);
        wait_cyc(1);
        chk("post_rst_outs", {db_level, db_rise, db_fall}, 32'd0);
        wait_cyc(45);
        chk("final_level", db_level, 32'hA);
        chk("q_empty_end", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/switch_scan_debouncer.md
Name: switch_scan_debouncer

Overview:
Multi-switch debounce controller for the Cyclone IV board. It replaces one-divider-per-switch debouncing with a shared sample-tick scheduler. A single prescaler generates the sample tick, and on each tick an FSM visits the N switches round-robin, one per clk cycle. Each visit updates a per-switch stability counter and produces a debounced level plus one-clk-wide rise and fall pulses in the clk domain.

Parameters:
N_SW, 4, number of raw switch inputs (1..16)
TICK_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); must be >= 2*N_SW, otherwise elaboration error
STABLE_CNT, 4, consecutive disagreeing samples needed to change a debounced level (2..255)

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous reset, active-high
sw  in  N_SW  raw asynchronous switch levels
db_level  out  N_SW  debounced level per switch
db_rise  out  N_SW  one-clk pulse when db_level bit goes 0->1
db_fall  out  N_SW  one-clk pulse when db_level bit goes 1->0
sample_tick  out  1  one-clk pulse marking the start of each scan

Behaviour:
- Reset (rst=1 at a clk edge): on the next edge, db_level, db_rise, db_fall and sample_tick are all 0. Prescaler, scan index, all stability counters and synchronizer flops clear to 0. FSM goes to IDLE. Reset mid-scan abandons the scan; no partial pulses follow.
- Synchronizer: 2-flop chain per sw bit, always running. sw_s is the second stage.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. sample_tick=1 for the cycle after the count equals TICK_DIV-1.
  - After reset release, the first sample_tick is high at clk cycle TICK_DIV.
- FSM states: IDLE, SCAN.
  - IDLE: when sample_tick=1, go to SCAN with idx=0.
  - SCAN: process switch idx in one cycle. If idx=N_SW-1, return to IDLE; otherwise idx+1.
  - A scan always lasts exactly N_SW cycles. Because of the TICK_DIV constraint, a tick never arrives during SCAN.
- Per-switch processing for switch i=idx, using the per-switch counter cnt[i] (width ceil(log2(STABLE_CNT))):
  - If sw_s[i]==db_level[i]: cnt[i] becomes 0.
  - Else if cnt[i]==STABLE_CNT-1: db_level[i] toggles and cnt[i] becomes 0. The next cycle has db_rise[i]=1 (new level 1) or db_fall[i]=1 (new level 0) for exactly one cycle.
  - Else: cnt[i] increments.
- Pulse rules:
  - At most one bit across db_rise|db_fall is high in any cycle.
  - Pulses appear only in the cycle after the switch's scan slot.
  - db_rise and db_fall are 0 in IDLE, except for the trailing pulse from the last slot.
- Counters never wrap: the maximum value is STABLE_CNT-1, then they clear.
- Latency for a clean edge on sw[i]: 2 clk of synchronizer, then STABLE_CNT ticks. The level changes at slot i of the STABLE_CNT-th scan that samples the new value; the pulse follows 1 clk later.
- Worst-case latency: 2 + STABLE_CNT*TICK_DIV + N_SW + 1 clk.
- Any bounce that returns sw_s to db_level before STABLE_CNT consecutive disagreeing samples clears cnt and causes no output change.
- Switches not being scanned keep their state. db_level changes only in the switch's own slot.

Test Plan (N_SW=4, TICK_DIV=10, STABLE_CNT=3):
1. Reset: rst=1 for 3 clk with sw=4'hF, then release. All outputs are 0 during reset and on the first edge after it. sample_tick first goes high 10 clk after release.
2. Clean press: sw=4'b0100 held from cycle 0 after reset. db_level=4'b0100 after slot 2 of the 3rd scan. db_rise=4'b0100 for exactly 1 clk; db_fall stays 0. Release sw later and expect a mirrored db_fall=4'b0100 pulse.
3. Bounce: sw[0] toggles every 7 clk for 60 clk, then holds 1. There is no db_rise during the bounce, then a single db_rise=4'b0001 three ticks after sw settles.
4. Simultaneous press: sw goes 0->4'hF. On the 3rd scan, db_rise is 0001, 0010, 0100, 1000 on 4 consecutive clk cycles. Final db_level=4'hF.
5. Short glitch: sw[3] high for 2 ticks then low. db_level[3] stays 0, no pulses, and cnt[3] returns to 0. A later clean 3-tick press still produces exactly one rise.
6. Reset mid-scan: assert rst during slot 1 of the scan that would produce a rise. The next cycle all outputs are 0 and the FSM is in IDLE. No pulse appears after release until sw is requalified over 3 ticks.
